// File: rtl/clk_gen_multi.sv
// clk_gen_multi: multi-channel programmable gated clock generator.
//
// Each channel divides the system clock into a 50%-duty clock whose high and
// low phases are each hp_eff cycles long. hp_eff is the channel's half_period
// value, with 0 treated as 1. Stopping a channel never cuts a phase short: a
// dropped enable is only acted on when a full low phase has completed, so no
// runt pulses appear on clk_out.
//
// Optional feature (macro CLK_GEN_MULTI_TICK_EN):
//   defined   -> extra output rise_tick, a one-cycle pulse per channel in the
//                first high cycle of every clk_out pulse (usable as a clock
//                enable for logic running on clk).
//   undefined -> rise_tick and its logic are absent; everything else is the
//                same.
//
// Handshake/observability: there is no valid/ready handshake. Each output bit
// is a registered level that holds for one full clk cycle. The per-channel
// FSM state can be read directly from the outputs:
//   {busy, clk_out} = 2'b00 IDLE, 2'b11 HIGH, 2'b10 LOW.
module clk_gen_multi #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         enable,
    input  logic [NUM_CH*CNT_W-1:0]   half_period,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         busy
`ifdef CLK_GEN_MULTI_TICK_EN
    ,
    output logic [NUM_CH-1:0]         rise_tick
`endif
);

    // Per-channel phase state; IDLE is the only state in which busy is low.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             clk_q;
        logic             busy_q;
        logic [CNT_W-1:0] hp_raw;
        logic [CNT_W-1:0] reload;

        // This channel's programmed half-period, sampled only at load points.
        assign hp_raw = half_period[i*CNT_W +: CNT_W];

        // Counter load value is hp_eff-1; half_period 0 and 1 both give 0,
        // which makes a phase exactly one cycle long.
        assign reload = (hp_raw == CNT_ZERO) ? CNT_ZERO : (hp_raw - CNT_ONE);

`ifdef CLK_GEN_MULTI_TICK_EN
        logic tick_q;
`endif

        // Phase FSM: counts each phase down and reloads it at the boundary,
        // with all outputs registered alongside the state.
        always_ff @(posedge clk) begin
            if (reset) begin
                state  <= ST_IDLE;
                cnt    <= CNT_ZERO;
                clk_q  <= 1'b0;
                busy_q <= 1'b0;
`ifdef CLK_GEN_MULTI_TICK_EN
                tick_q <= 1'b0;
`endif
            end else begin
`ifdef CLK_GEN_MULTI_TICK_EN
                tick_q <= 1'b0;
`endif
                case (state)
                    ST_IDLE: begin
                        if (enable[i]) begin
                            state  <= ST_HIGH;
                            cnt    <= reload;
                            clk_q  <= 1'b1;
                            busy_q <= 1'b1;
`ifdef CLK_GEN_MULTI_TICK_EN
                            tick_q <= 1'b1;
`endif
                        end
                    end

                    ST_HIGH: begin
                        if (cnt != CNT_ZERO) begin
                            cnt <= cnt - CNT_ONE;
                        end else begin
                            // The low phase length is taken from half_period
                            // as it stands at this boundary.
                            state <= ST_LOW;
                            cnt   <= reload;
                            clk_q <= 1'b0;
                        end
                    end

                    ST_LOW: begin
                        if (cnt != CNT_ZERO) begin
                            cnt <= cnt - CNT_ONE;
                        end else if (enable[i]) begin
                            // Enable still (or again) high at the end of the
                            // low phase: continue without a gap.
                            state  <= ST_HIGH;
                            cnt    <= reload;
                            clk_q  <= 1'b1;
`ifdef CLK_GEN_MULTI_TICK_EN
                            tick_q <= 1'b1;
`endif
                        end else begin
                            // Full low phase done and enable gone: stop clean.
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end

                    default: begin
                        state  <= ST_IDLE;
                        cnt    <= CNT_ZERO;
                        clk_q  <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end

        assign clk_out[i] = clk_q;
        assign busy[i]    = busy_q;
`ifdef CLK_GEN_MULTI_TICK_EN
        assign rise_tick[i] = tick_q;
`endif
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// tb_clk_gen_multi: self-checking bench for clk_gen_multi (NUM_CH=2, CNT_W=8).
//
// The reference model describes each channel as a queue of future output
// cycles. Whenever a channel's queue runs dry it schedules the next whole
// segment: a high pulse of hp_eff cycles (only if enable is high), or, after a
// high pulse, a low gap of hp_eff cycles. The expected outputs for every edge
// go into exp_q and a negedge monitor pops and compares them against the DUT.
module tb_clk_gen_multi;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;

    logic                    clk;
    logic                    reset;
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH*CNT_W-1:0] half_period;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       busy;
`ifdef CLK_GEN_MULTI_TICK_EN
    logic [NUM_CH-1:0]       rise_tick;
`endif

    clk_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .half_period (half_period),
        .clk_out     (clk_out),
        .busy        (busy)
`ifdef CLK_GEN_MULTI_TICK_EN
        ,
        .rise_tick   (rise_tick)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    // Expected response per edge: {tick, busy, clk_out}, NUM_CH bits each.
    logic [3*NUM_CH-1:0] exp_q[$];
    // Per-channel pending waveform entries: {clk, busy, tick}.
    logic [2:0]          wave_q[NUM_CH][$];
    bit                  after_high[NUM_CH];

    int checks = 0;
    int errors = 0;

    function automatic int hp_eff(input logic [CNT_W-1:0] v);
        return (v == '0) ? 1 : int'(v);
    endfunction

    // Reference model: turns the inputs seen at each edge into expected outputs.
    always @(posedge clk) begin
        logic [NUM_CH-1:0] e_clk;
        logic [NUM_CH-1:0] e_busy;
        logic [NUM_CH-1:0] e_tick;
        logic [2:0]        ent;
        int                h;
        e_clk  = '0;
        e_busy = '0;
        e_tick = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (reset) begin
                wave_q[ch].delete();
                after_high[ch] = 1'b0;
            end else begin
                if (wave_q[ch].size() == 0) begin
                    h = hp_eff(half_period[ch*CNT_W +: CNT_W]);
                    if (after_high[ch]) begin
                        for (int k = 0; k < h; k++) wave_q[ch].push_back(3'b010);
                        after_high[ch] = 1'b0;
                    end else if (enable[ch]) begin
                        for (int k = 0; k < h; k++)
                            wave_q[ch].push_back((k == 0) ? 3'b111 : 3'b110);
                        after_high[ch] = 1'b1;
                    end
                end
                ent = (wave_q[ch].size() > 0) ? wave_q[ch].pop_front() : 3'b000;
                e_clk[ch]  = ent[2];
                e_busy[ch] = ent[1];
                e_tick[ch] = ent[0];
            end
        end
        exp_q.push_back({e_tick, e_busy, e_clk});
    end

    // Monitor: compares each registered output against the oldest expectation.
    always @(negedge clk) begin
        logic [3*NUM_CH-1:0] exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (clk_out !== exp[NUM_CH-1:0]) begin
                errors++;
                $display("FAIL clk_out cyc=%0d got=%b exp=%b", cyc, clk_out, exp[NUM_CH-1:0]);
            end
            checks++;
            if (busy !== exp[2*NUM_CH-1:NUM_CH]) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp[2*NUM_CH-1:NUM_CH]);
            end
`ifdef CLK_GEN_MULTI_TICK_EN
            checks++;
            if (rise_tick !== exp[3*NUM_CH-1:2*NUM_CH]) begin
                errors++;
                $display("FAIL rise_tick cyc=%0d got=%b exp=%b", cyc, rise_tick,
                         exp[3*NUM_CH-1:2*NUM_CH]);
            end
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_hp(input int ch, input int v);
        half_period[ch*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    // Waits (bounded) until channel ch shows the requested {busy, clk_out}.
    task automatic wait_phase(input int ch, input logic want_busy, input logic want_clk,
                              input int max_cyc, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (busy[ch] === want_busy && clk_out[ch] === want_clk) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s cyc=%0d got=timeout exp=phase within %0d cycles", name, cyc, max_cyc);
        end
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        step(n);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b1;
        enable      = '0;
        half_period = '0;

        // Basic divide: ch0 hp=5, ch1 hp=10, staggered enables.
        step(3);
        reset = 1'b0;
        set_hp(0, 5);
        set_hp(1, 10);
        step(6);
        enable[1] = 1'b1;
        step(10);
        enable[0] = 1'b1;
        step(60);
        enable = '0;
        step(25);

        // Glitch-free stop: drop enable one cycle into a HIGH phase.
        set_hp(0, 4);
        enable[0] = 1'b1;
        wait_phase(0, 1'b1, 1'b1, 20, "stop_rise");
        step(1);
        enable[0] = 1'b0;
        step(14);

        // Re-enable inside the same LOW phase: no gap in the clock.
        set_hp(0, 3);
        enable[0] = 1'b1;
        wait_phase(0, 1'b1, 1'b0, 20, "reen_low");
        enable[0] = 1'b0;
        step(1);
        enable[0] = 1'b1;
        step(20);
        enable[0] = 1'b0;
        step(10);

        // Boundary half-periods: 0 behaves as 1, 255 is the maximum.
        set_hp(0, 0);
        enable[0] = 1'b1;
        step(12);
        set_hp(0, 1);
        step(8);
        enable[0] = 1'b0;
        set_hp(1, 255);
        enable[1] = 1'b1;
        wait_phase(1, 1'b1, 1'b1, 10, "hp255_rise");
        enable[1] = 1'b0;
        step(520);

        // Mid-HIGH reprogram 6 -> 2: current high stays 6, next low is 2.
        set_hp(0, 6);
        enable[0] = 1'b1;
        wait_phase(0, 1'b1, 1'b1, 20, "reprog_rise");
        step(2);
        set_hp(0, 2);
        step(16);

        // Reset mid-HIGH with enable held, then idle, then restart.
        wait_phase(0, 1'b1, 1'b1, 20, "rst_rise");
        step(1);
        pulse_reset(2);
        enable[0] = 1'b0;
        step(8);
        enable[0] = 1'b1;
        step(12);

        // Randomized run on both channels.
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            reset = 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(0, 19) == 0) enable[ch] = ~enable[ch];
                if ($urandom_range(0, 29) == 0) set_hp(ch, int'($urandom_range(0, 6)));
            end
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
        end
        reset  = 1'b0;
        enable = '0;
        step(40);

        // Let the last pushed expectation be compared.
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_gen_multi.md
Name: clk_gen_multi

Overview:
- Multi-channel, programmable, gated clock generator.
- Each channel derives a 50%-duty divided clock from the single system clock.
- Programmable half-period per channel; per-channel enable with glitch-free stop, so no runt pulses are generated on disable.
- Replaces the single fixed-delay behavioural clock source with a synthesizable, parametrised block for stimulus and on-chip divided clocks.

Parameters:
NUM_CH, 2, number of independent output channels (>=1)
CNT_W, 8, width of each channel's half-period value and counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  NUM_CH  per-channel run request; bit i controls channel i
half_period  input  NUM_CH*CNT_W  channel i half-period in clk cycles, bits [i*CNT_W +: CNT_W]
clk_out  output  NUM_CH  registered divided clock per channel
busy  output  NUM_CH  channel i not in IDLE

Behaviour:
- Channels are fully independent and identical; each has state {IDLE, HIGH, LOW}, a CNT_W down-counter and a latched half-period.
- Reset (sampled at a clk edge with reset=1):
  - all states go to IDLE; clk_out=0, busy=0, counters=0.
  - Reset overrides everything, including mid-HIGH; the truncated pulse is accepted.
- Effective half-period: hp_eff = half_period_i, or 1 if half_period_i==0. Range is 1..2^CNT_W-1.
- IDLE:
  - clk_out=0.
  - At an edge with enable_i=1: go to HIGH; clk_out=1 from that edge; counter = hp_eff-1.
  - Enable-to-rise latency is therefore one edge.
- HIGH:
  - Counter !=0: decrement.
  - Counter ==0: go to LOW; clk_out=0; counter = hp_eff-1, with hp_eff resampled at this edge.
- LOW:
  - Counter !=0: decrement.
  - Counter ==0 and enable_i=1: go to HIGH; clk_out=1; reload counter.
  - Counter ==0 and enable_i=0: go to IDLE.
- Steady state:
  - clk_out is high exactly hp_eff cycles and low exactly hp_eff cycles; period 2*hp_eff.
  - hp_eff=1 gives a clk/2 toggle.
- Enable semantics:
  - enable_i is sampled only in IDLE and at the LOW-phase end.
  - Deassert during HIGH or LOW: the current high and low phases complete in full, then IDLE. Last low phase is full length.
  - Deassert then reassert before the LOW phase ends: no gap, continuous clock.
  - Reassert in IDLE: restarts after one edge as above.
- half_period changes take effect only at phase boundaries (load points). Mid-phase changes never shorten or stretch the current phase.
- busy_i = (state != IDLE), registered; busy is asserted in the same cycles the state is HIGH or LOW.
- No cross-channel interaction. Simultaneous enables start their channels in phase on the same edge.

Optional Feature:
- Macro: CLK_GEN_MULTI_TICK_EN.
- Defined: extra output port rise_tick (output, NUM_CH).
  - rise_tick_i is a one-cycle pulse, high exactly in the cycles where clk_out_i has just transitioned 0->1 (IDLE->HIGH and LOW->HIGH).
  - Reset value 0.
  - Intended as a clock-enable for logic in the clk domain.
- Undefined: port rise_tick and its logic are absent; all other behaviour is identical.

Test Plan (NUM_CH=2, CNT_W=8 unless noted):
- Basic divide:
  - Stimulus: reset for 3 cycles; ch0 hp=5, ch1 hp=10; enable[1]=1 at cycle 10, enable[0]=1 at cycle 20.
  - Response: clk_out[1] rises on edge 10 with period 20 (10 high / 10 low); clk_out[0] rises on edge 20 with period 10 (5 high / 5 low); busy tracks each channel.
- Glitch-free stop:
  - Stimulus: ch0 hp=4 running; drop enable[0] 1 cycle into a HIGH phase.
  - Response: 3 more high cycles, then 4 low cycles, then IDLE with busy[0]=0; no pulse shorter than 4 cycles.
- Re-enable during LOW:
  - Stimulus: hp=3; drop enable then raise it again within the same LOW phase.
  - Response: clk_out continuous with period 6, no gap; busy never drops.
- Boundary half-periods:
  - Stimulus: hp=0.
  - Response: clk_out toggles every cycle (period 2), same as hp=1.
  - Stimulus: hp=255.
  - Response: 255 high / 255 low cycles.
- Mid-phase reprogram and reset:
  - Stimulus: hp 6->2 written mid-HIGH.
  - Response: current HIGH stays 6 cycles; the following LOW is 2 cycles.
  - Stimulus: assert reset mid-HIGH.
  - Response: clk_out=0 and busy=0 after that edge; stays IDLE until enable is seen after reset is released.
- With CLK_GEN_MULTI_TICK_EN defined:
  - Stimulus: hp=5.
  - Response: rise_tick[0] is high exactly 1 cycle every 10, coincident with the first high cycle of clk_out[0]; rise_tick is 0 under reset.
